repetition_window_monitor: RTL and testbench
============================================

// Module: repetition_window_monitor
// PURPOSE
//  Synthesizable hardware checker for repetition properties of the form "trig rises |-> guard throughout evt[->N]"
//  and "trig rises |-> exactly min..max evt hits within a window".
//  Sits downstream of the stimulus/DUT signals that the SVA benches exercise, and upstream of the pass/fail scoreboard.
//  Gives on-chip and FPGA builds the same verdicts the simulation assertions give.
// PARAMETERS
//  CNT_W  4  width of the event counter and of the cfg_min/cfg_max fields
//  TMO_W  8  width of the window/timeout counter and of cfg_timeout
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-high
//  cfg_mode     in   1      0 = GOTO (evt[->min]), 1 = WINDOW (evt[=min:max] counted over the full window)
//  cfg_min      in   CNT_W  minimum required evt hits
//  cfg_max      in   CNT_W  maximum allowed hits (WINDOW mode only)
//  cfg_timeout  in   TMO_W  window length in cycles; 0 is treated as 1
//  trig         in   1      antecedent; only its rising edge arms the monitor
//  evt          in   1      repeated event; each high sampled cycle counts as one hit
//  guard        in   1      must be high in every armed cycle ("throughout")
//  busy         out  1      high while in ARMED
//  pass         out  1      1-cycle pulse: property satisfied
//  fail         out  1      1-cycle pulse: property violated
//  fail_code    out  2      valid with fail: 01 GUARD, 10 TIMEOUT, 11 OVERCOUNT
//  evt_count    out  CNT_W  hits counted in the current or last attempt; saturates at all-ones
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE; trig_q, busy, pass, fail=0; fail_code=00; evt_count=0; timer=0.
//  Edge detect: rose = trig & ~trig_q; trig_q is registered every cycle, including outside IDLE.
//  FSM states: IDLE, ARMED, DONE.
//   IDLE: on rose, latch cfg_*, go to ARMED. The trigger cycle is armed cycle 1 (overlapping implication).
//     In that cycle guard and evt are already evaluated: evt_count=evt, timer=1.
//   ARMED: each cycle timer+=1 and evt_count+=evt (saturating). Checks are evaluated on the current sampled
//     inputs, in priority order:
//     1 guard==0                                          -> fail, GUARD
//     2 GOTO: count_next>=cfg_min                         -> pass (first-match, the hit cycle)
//       WINDOW: count_next>cfg_max                        -> fail, OVERCOUNT (early)
//     3 timer==cfg_timeout: GOTO -> fail, TIMEOUT (strong semantics)
//       WINDOW: pass if cfg_min<=count<=cfg_max, else fail, TIMEOUT
//     Any verdict moves the FSM to DONE.
//   DONE: pass or fail is high for exactly this one cycle, then return to IDLE. evt_count holds until the next arm.
//  Latency: verdict pulse appears one clk after the deciding sample edge.
//  Flag exclusivity: pass and fail are never high together; busy=0 in IDLE and DONE.
//  cfg_min==0, GOTO mode: passes on the trigger cycle if guard=1.
//  cfg_min>cfg_max, WINDOW mode: can never pass; resolves as OVERCOUNT or TIMEOUT.
//  Retrigger: a rose while in ARMED or DONE is ignored; no overlapping attempts.
//  Same-cycle conflicts: guard drop together with the final hit gives GUARD.
//    In GOTO mode, the final hit on the timeout cycle gives pass.
//  Reset mid-attempt: abort with no verdict pulse; all outputs take their reset values.
//  Config is sampled only at arm; changes while ARMED have no effect.
// TESTING (clk period 10, first posedge at 5)
//  T1 GOTO min=3 tmo=20: trig 15-25, evt high 20-50 (posedges 25,35,45)
//     -> pass pulse in the cycle after posedge 45; evt_count=3.
//  T2 GOTO min=3, evt pulses only at posedges 25 and 65, tmo=8
//     -> fail, TIMEOUT (10) at timer=8; evt_count=2.
//  T3 as T1, but guard falls at t=40 -> fail, GUARD (01) after posedge 45; no pass.
//  T4 WINDOW min=3 max=5 tmo=10, 4 hits -> pass after window end (timer=10), not at the 3rd hit.
//  T5 WINDOW min=1 max=2, evt high 3 consecutive cycles
//     -> fail, OVERCOUNT (11) on the 3rd hit, before timeout.
//  T6 second trig rise while busy, then rst pulse mid-ARMED
//     -> no new arm; after rst no pass/fail, busy=0, evt_count=0.

Source files
------------

// File: rtl/repetition_window_monitor.sv
// repetition_window_monitor: on-chip checker for "trig rises |-> guard throughout evt[->N]" and windowed evt-count properties
module repetition_window_monitor #(
  parameter int CNT_W = 4,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_min,
  input  logic [CNT_W-1:0] cfg_max,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             trig,
  input  logic             evt,
  input  logic             guard,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] evt_count
);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t           state_q, state_d;
  logic             trig_q, mode_q, mode_d, pass_q, pass_d;
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d, cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, timer_q, timer_d;
  logic [1:0]       code_q, code_d;
  logic             arm, active, hit, over, expire, in_win;

  // state, latched config, counters and verdict registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      mode_q  <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      pass_q  <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      trig_q  <= trig;
      mode_q  <= mode_d;
      min_q   <= min_d;
      max_q   <= max_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
    end
  end

  // next state: the trigger cycle is armed cycle 1 and is judged with the live config and inputs
  always_comb begin
    arm     = state_q == IDLE && trig && !trig_q;
    active  = arm || state_q == ARMED;
    mode_d  = arm ? cfg_mode : mode_q;
    min_d   = arm ? cfg_min : min_q;
    max_d   = arm ? cfg_max : max_q;
    tmo_d   = !arm ? tmo_q : cfg_timeout == '0 ? TMO_W'(1) : cfg_timeout;
    cnt_d   = !active ? cnt_q : arm ? CNT_W'(evt) : &cnt_q ? cnt_q : cnt_q + CNT_W'(evt);
    timer_d = !active ? timer_q : arm ? TMO_W'(1) : timer_q + TMO_W'(1);
    hit     = !mode_d && cnt_d >= min_d;
    over    = mode_d && cnt_d > max_d;
    expire  = timer_d == tmo_d;
    in_win  = cnt_d >= min_d && cnt_d <= max_d;
    pass_d  = guard && (hit || (mode_d && expire && in_win));
    code_d  = !guard ? 2'b01 : over ? 2'b11 : 2'b10;
    state_d = active && (!guard || hit || over || expire) ? DONE : active ? ARMED : IDLE;
  end

  // outputs: verdict pulses live only in DONE, fail_code qualified by fail
  always_comb begin
    busy      = state_q == ARMED;
    pass      = state_q == DONE && pass_q;
    fail      = state_q == DONE && !pass_q;
    fail_code = state_q == DONE && !pass_q ? code_q : 2'b00;
    evt_count = cnt_q;
  end
endmodule

// File: tb/tb_repetition_window_monitor.sv
// tb_repetition_window_monitor: scoreboard bench with directed scenarios and randomized attempts
module tb_repetition_window_monitor;
  logic       clk = 1'b0;
  logic       rst, cfg_mode, trig, evt, guard;
  logic [3:0] cfg_min, cfg_max;
  logic [7:0] cfg_timeout;
  logic       busy, pass, fail;
  logic [1:0] fail_code;
  logic [3:0] evt_count;

  repetition_window_monitor dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .cfg_timeout(cfg_timeout), .trig(trig), .evt(evt), .guard(guard), .busy(busy),
    .pass(pass), .fail(fail), .fail_code(fail_code), .evt_count(evt_count)
  );

  always #5 clk = ~clk;

  typedef struct {bit p; int c; int cnt; int cyc;} exp_t;
  exp_t sb[$];
  int   total = 0, bad = 0, cyc_n = 0;
  bit   ev[256], gd[256];

  always @(posedge clk) cyc_n++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // reference: walk the sampled sequence in the property's own terms
  task automatic model(input bit md, input int mn, input int mx, input int tm,
                       output int k, output bit p, output int c, output int cnt);
    int t = tm == 0 ? 1 : tm;
    cnt = 0; k = t; p = 0; c = 2;
    for (int i = 1; i <= t; i++) begin
      cnt = cnt + int'(ev[i]) > 15 ? 15 : cnt + int'(ev[i]);
      if (!gd[i]) begin k = i; p = 0; c = 1; return; end
      if (!md && cnt >= mn) begin k = i; p = 1; c = 0; return; end
      if (md && cnt > mx) begin k = i; p = 0; c = 3; return; end
      if (i == t) begin
        k = i;
        p = md && cnt >= mn && cnt <= mx;
        c = p ? 0 : 2;
        return;
      end
    end
  endtask

  task automatic attempt(input bit md, input int mn, input int mx, input int tm);
    int k, c, cnt;
    bit p;
    model(md, mn, mx, tm, k, p, c, cnt);
    @(negedge clk);
    cfg_mode = md; cfg_min = mn[3:0]; cfg_max = mx[3:0]; cfg_timeout = tm[7:0];
    trig = 1'b1; evt = ev[1]; guard = gd[1];
    sb.push_back('{p, c, cnt, cyc_n + k});
    for (int i = 2; i <= k; i++) begin
      @(negedge clk);
      evt = ev[i]; guard = gd[i]; trig = 1'($urandom);
      cfg_mode = 1'($urandom); cfg_min = 4'($urandom); cfg_max = 4'($urandom); cfg_timeout = 8'($urandom);
    end
    @(negedge clk);
    trig = 1'b0; evt = 1'($urandom); guard = 1'($urandom);
    @(negedge clk);
    chk("evt_count_hold", int'(evt_count), cnt);
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 256; i++) begin ev[i] = 1'b0; gd[i] = 1'b1; end
  endtask

  // monitor: every verdict pulse must match the oldest expected attempt
  always @(negedge clk) begin
    exp_t e;
    if (pass || fail) begin
      chk("exclusive", int'(pass & fail), 0);
      chk("busy_at_verdict", int'(busy), 0);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_verdict: got pass=%0b fail=%0b expected none (cycle %0d)", pass, fail, cyc_n);
      end else begin
        e = sb.pop_front();
        chk("verdict_pass", int'(pass), int'(e.p));
        if (!e.p) chk("fail_code", int'(fail_code), e.c);
        chk("evt_count", int'(evt_count), e.cnt);
        chk("verdict_cycle", cyc_n, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; trig = 1'b0; evt = 1'b0; guard = 1'b1;
    cfg_mode = 1'b0; cfg_min = 4'd0; cfg_max = 4'd0; cfg_timeout = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_code", int'(fail_code), 0);
    chk("rst_count", int'(evt_count), 0);
    rst = 1'b0;
    @(negedge clk);
    // T1 GOTO min=3: hits on armed cycles 2..4
    clear_seq(); ev[2] = 1; ev[3] = 1; ev[4] = 1;
    attempt(1'b0, 3, 0, 20);
    // T2 GOTO min=3, two hits, timeout 8
    clear_seq(); ev[2] = 1; ev[6] = 1;
    attempt(1'b0, 3, 0, 8);
    // T3 guard drops on the final hit
    clear_seq(); ev[2] = 1; ev[3] = 1; ev[4] = 1; gd[4] = 0;
    attempt(1'b0, 3, 0, 20);
    // T4 WINDOW 3..5 with 4 hits: pass only at window end
    clear_seq(); ev[2] = 1; ev[3] = 1; ev[4] = 1; ev[5] = 1;
    attempt(1'b1, 3, 5, 10);
    // T5 WINDOW 1..2, three consecutive hits: early overcount
    clear_seq(); ev[2] = 1; ev[3] = 1; ev[4] = 1;
    attempt(1'b1, 1, 2, 10);
    // boundaries: min=0 GOTO, timeout=0, saturation, min>max, final hit on timeout cycle
    clear_seq(); attempt(1'b0, 0, 0, 20);
    clear_seq(); ev[1] = 1; attempt(1'b0, 4, 0, 0);
    clear_seq(); for (int i = 1; i < 256; i++) ev[i] = 1; attempt(1'b1, 0, 15, 20);
    clear_seq(); attempt(1'b1, 5, 2, 6);
    clear_seq(); ev[3] = 1; ev[5] = 1; attempt(1'b0, 2, 0, 5);
    // T6 retrigger while busy, then reset mid-attempt
    clear_seq();
    @(negedge clk);
    cfg_mode = 1'b0; cfg_min = 4'd9; cfg_max = 4'd0; cfg_timeout = 8'd50;
    trig = 1'b1; evt = 1'b1; guard = 1'b1;
    @(negedge clk); trig = 1'b0;
    @(negedge clk); trig = 1'b1;
    @(negedge clk);
    chk("t6_busy_retrig", int'(busy), 1);
    chk("t6_count_running", int'(evt_count), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; trig = 1'b0; evt = 1'b0;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_count", int'(evt_count), 0);
    chk("t6_rst_pass", int'(pass), 0);
    chk("t6_rst_fail", int'(fail), 0);
    repeat (3) @(negedge clk);
    chk("t6_idle_busy", int'(busy), 0);
    // randomized attempts
    for (int n = 0; n < 60; n++) begin
      int dens = $urandom_range(1, 4);
      for (int i = 0; i < 256; i++) begin
        ev[i] = $urandom_range(0, dens) == 0;
        gd[i] = $urandom_range(0, 30) != 0;
      end
      attempt(1'($urandom), $urandom_range(0, 6), $urandom_range(0, 8), $urandom_range(0, 30));
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
